// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for the two-input logic-gate unit: walks A/B through all four
// vectors, captures the seven gate outputs per vector and compares against the golden table.
module gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  gate_in,
  output logic        drv_a,
  output logic        drv_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [6:0]  fail_mask,
  output logic [27:0] truth_table
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic [6:0] mask_next;

  // Expected {xnor, xor, nor, nand, or, and, not} for A=v[1], B=v[0].
  function automatic logic [6:0] golden(input logic [1:0] v);
    case (v)
      2'd0:    golden = 7'h59;
      2'd1:    golden = 7'h2D;
      2'd2:    golden = 7'h2C;
      default: golden = 7'h46;
    endcase
  endfunction

  assign mask_next = fail_mask | (gate_in ^ golden(vec));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      vec         <= 2'd0;
      cnt         <= 4'd0;
      drv_a       <= 1'b0;
      drv_b       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_mask   <= 7'd0;
      truth_table <= 28'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SETTLE;
            vec         <= 2'd0;
            drv_a       <= 1'b0;
            drv_b       <= 1'b0;
            fail_mask   <= 7'd0;
            truth_table <= 28'd0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            cnt         <= RELOAD;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) state <= SAMPLE;
          else             cnt   <= cnt - 4'd1;
        end
        SAMPLE: begin
          truth_table[7*int'(vec) +: 7] <= gate_in;
          fail_mask                     <= mask_next;
          if (vec == 2'd3) begin
            // Drive is left at 11 and held through IDLE.
            state <= DONE;
            done  <= 1'b1;
            pass  <= (mask_next == 7'd0);
          end else begin
            vec            <= vec + 2'd1;
            {drv_a, drv_b} <= vec + 2'd1;
            cnt            <= RELOAD;
            state          <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: behavioural gate unit with injectable stuck-at faults,
// two DUTs (settle 2 and settle 1), directed and randomized sweeps.
module tb_gate_bist_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1;
  logic [6:0]  sa0, sa1;
  logic [6:0]  gi0, gi1;
  logic        a0, b0, busy0, done0, pass0;
  logic        a1, b1, busy1, done1, pass1;
  logic [6:0]  mask0, mask1;
  logic [27:0] tt0, tt1;

  int n_assert = 0;
  int n_fail   = 0;
  int sel      = 0;

  function automatic logic [6:0] gates(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
  endfunction

  assign gi0 = (gates(a0, b0) & ~sa0) | sa1;
  assign gi1 = (gates(a1, b1) & ~sa0) | sa1;

  gate_bist_ctrl #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_in(gi0),
    .drv_a(a0), .drv_b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(mask0), .truth_table(tt0)
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_in(gi1),
    .drv_a(a1), .drv_b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(mask1), .truth_table(tt1)
  );

  logic [1:0]  o_drv;
  logic        o_busy, o_done, o_pass;
  logic [6:0]  o_mask;
  logic [27:0] o_tt;
  assign o_drv  = (sel == 1) ? {a1, b1} : {a0, b0};
  assign o_busy = (sel == 1) ? busy1 : busy0;
  assign o_done = (sel == 1) ? done1 : done0;
  assign o_pass = (sel == 1) ? pass1 : pass0;
  assign o_mask = (sel == 1) ? mask1 : mask0;
  assign o_tt   = (sel == 1) ? tt1 : tt0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl0"}, {a0, b0, busy0, done0, pass0, mask0}, 32'd0);
    chk({tag, "_tt0"}, tt0, 32'd0);
    chk({tag, "_ctl1"}, {a1, b1, busy1, done1, pass1, mask1}, 32'd0);
    chk({tag, "_tt1"}, tt1, 32'd0);
  endtask

  task automatic set_start(input logic val);
    if (sel == 1) start1 = val;
    else          start0 = val;
  endtask

  // One sweep; per cycle k after the accept edge, the expected drive is vector k/(S+1),
  // done sits at k=4(S+1), busy covers k=0..4(S+1).
  task automatic run_sweep(input int which, input logic [6:0] f0, input logic [6:0] f1,
                           input int mid_k, input bit hold_end, input bit pre_started);
    int p, l, v;
    logic [6:0]  g, o, e_mask;
    logic [27:0] e_tt;
    sel = which;
    p   = (which == 1) ? 2 : 3;
    l   = 4 * p;
    sa0 = f0;
    sa1 = f1;
    e_tt   = '0;
    e_mask = '0;
    for (int i = 0; i < 4; i++) begin
      g = gates(i[1], i[0]);
      o = (g & ~f0) | f1;
      e_tt[7*i +: 7] = o;
      e_mask |= o ^ g;
    end
    if (!pre_started) begin
      @(negedge clk);
      set_start(1'b1);
    end
    for (int k = 0; k <= l + 1; k++) begin
      @(negedge clk);
      if (k == 0 || k == mid_k + 1) set_start(1'b0);
      if (k == mid_k) set_start(1'b1);
      if (hold_end && k == l) set_start(1'b1);
      v = (k < l) ? k / p : 3;
      chk("drv", o_drv, v[1:0]);
      chk("busy", o_busy, (k <= l));
      chk("done", o_done, (k == l));
      if (k == 0) begin
        chk("clr_tt", o_tt, 32'd0);
        chk("clr_mask", o_mask, 32'd0);
        chk("clr_pass", o_pass, 32'd0);
      end
      if (k >= l) begin
        chk("truth_table", o_tt, e_tt);
        chk("fail_mask", o_mask, e_mask);
        chk("pass", o_pass, (e_mask == 7'd0));
      end
    end
  endtask

  initial begin
    int          which, mk, gap;
    logic [6:0]  f0, f1;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sa0 = '0; sa1 = '0;
    #1;
    chk_zero("reset_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_zero("idle_no_start");
    end

    // Fault-free sweep with settle 2
    run_sweep(0, 7'd0, 7'd0, -1, 1'b0, 1'b0);
    chk("golden_tt", tt0, 32'h8CB16D9);
    chk("golden_pass", pass0, 32'd1);

    // and output stuck-at-0
    run_sweep(0, 7'b0000010, 7'd0, -1, 1'b0, 1'b0);
    chk("sa0_and_tt_v3", tt0[27:21], 32'h44);
    chk("sa0_and_mask", mask0, 32'h02);
    chk("sa0_and_pass", pass0, 32'd0);

    // start pulsed during vector 1, then held through DONE into a back-to-back sweep
    run_sweep(0, 7'd0, 7'd0, 4, 1'b1, 1'b0);
    run_sweep(0, 7'd0, 7'd0, -1, 1'b0, 1'b1);

    // reset during vector 2
    sel = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_drv", {a0, b0}, 32'd2);
    chk("pre_rst_busy", busy0, 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero("reset_mid");
    @(negedge clk); rst = 1'b0;
    run_sweep(0, 7'd0, 7'd0, -1, 1'b0, 1'b0);
    chk("post_rst_pass", pass0, 32'd1);

    // settle 1
    run_sweep(1, 7'd0, 7'd0, -1, 1'b0, 1'b0);
    chk("s1_pass", pass1, 32'd1);
    chk("s1_tt", tt1, 32'h8CB16D9);

    // randomized fault patterns, idle gaps and ignored mid-sweep starts
    for (int r = 0; r < 8; r++) begin
      which = int'($urandom_range(0, 1));
      f0    = 7'($urandom) & 7'($urandom);
      f1    = 7'($urandom) & 7'($urandom) & ~f0;
      mk    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -1;
      gap   = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      run_sweep(which, f0, f1, mk, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
